// File: rtl/rv32i_writeback_if.sv
// Writeback stage bundle: memory-stage result in,
// register-file write port and stall out.
interface rv32i_writeback_if;
  logic        i_ce;
  logic        i_flush;
  logic [4:0]  i_rd_addr;
  logic        i_wr_rd;
  logic [31:0] i_alu_result;
  logic [31:0] i_csr_out;
  logic        i_opcode_load;
  logic        i_opcode_system;
  logic [2:0]  i_funct3;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_ce_stage5;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;
  logic        o_wr;
  logic        o_stall;

  modport master (
    output i_ce, i_flush, i_rd_addr, i_wr_rd,
    output i_alu_result, i_csr_out,
    output i_opcode_load, i_opcode_system,
    output i_funct3, i_mem_rdata, i_mem_ack,
    input  o_ce_stage5, o_rd_addr, o_rd,
    input  o_wr, o_stall
  );

  modport slave (
    input  i_ce, i_flush, i_rd_addr, i_wr_rd,
    input  i_alu_result, i_csr_out,
    input  i_opcode_load, i_opcode_system,
    input  i_funct3, i_mem_rdata, i_mem_ack,
    output o_ce_stage5, o_rd_addr, o_rd,
    output o_wr, o_stall
  );
endinterface

// File: rtl/rv32i_writeback.sv
// RV32I stage 5: load alignment, result select,
// registered register-file write port, load stall.
module rv32i_writeback (
  input logic            i_clk,
  input logic            i_rst_n,
  rv32i_writeback_if.slave bus
);

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] rd_n;
  logic [4:0]  addr_n;
  logic        wr_n;
  logic [4:0]  l_addr, l_addr_n;
  logic        l_wr, l_wr_n;
  logic [2:0]  l_f3, l_f3_n;
  logic [1:0]  l_off, l_off_n;
  logic        ce;

  function automatic logic [31:0] align(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    // off[0] is ignored for halfwords
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign bus.o_stall     = (state == WAIT_LOAD);
  assign ce              = bus.i_ce & ~bus.o_stall
                         & ~bus.i_flush;
  assign bus.o_ce_stage5 = ce;

  // next state, next write-port values, load latches
  always_comb begin
    state_n  = state;
    rd_n     = bus.o_rd;
    addr_n   = bus.o_rd_addr;
    wr_n     = 1'b0;
    l_addr_n = l_addr;
    l_wr_n   = l_wr;
    l_f3_n   = l_f3;
    l_off_n  = l_off;
    case (state)
      RUN: begin
        if (ce) begin
          if (bus.i_opcode_load && !bus.i_mem_ack) begin
            l_addr_n = bus.i_rd_addr;
            l_wr_n   = bus.i_wr_rd;
            l_f3_n   = bus.i_funct3;
            l_off_n  = bus.i_alu_result[1:0];
            state_n  = WAIT_LOAD;
          end else begin
            addr_n = bus.i_rd_addr;
            wr_n   = bus.i_wr_rd & (|bus.i_rd_addr);
            if (bus.i_opcode_load)
              rd_n = align(bus.i_mem_rdata,
                           bus.i_funct3,
                           bus.i_alu_result[1:0]);
            else if (bus.i_opcode_system)
              rd_n = bus.i_csr_out;
            else
              rd_n = bus.i_alu_result;
          end
        end
      end
      WAIT_LOAD: begin
        // flush wins over a same-cycle ack
        if (bus.i_flush) begin
          state_n = RUN;
        end else if (bus.i_mem_ack) begin
          rd_n    = align(bus.i_mem_rdata, l_f3, l_off);
          addr_n  = l_addr;
          wr_n    = l_wr & (|l_addr);
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // state, registered write port and load latches
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= RUN;
      bus.o_rd      <= 32'd0;
      bus.o_rd_addr <= 5'd0;
      bus.o_wr      <= 1'b0;
      l_addr        <= 5'd0;
      l_wr          <= 1'b0;
      l_f3          <= 3'd0;
      l_off         <= 2'd0;
    end else begin
      state         <= state_n;
      bus.o_rd      <= rd_n;
      bus.o_rd_addr <= addr_n;
      bus.o_wr      <= wr_n;
      l_addr        <= l_addr_n;
      l_wr          <= l_wr_n;
      l_f3          <= l_f3_n;
      l_off         <= l_off_n;
    end
  end

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed and randomized checks of rv32i_writeback
// against a small behavioural model.
module tb_rv32i_writeback;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  logic [31:0] exp_rd;
  logic [4:0]  exp_addr;

  rv32i_writeback_if bus ();

  rv32i_writeback dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_load(
    input logic [31:0] w, input int f3, input int off);
    longint unsigned wv, b, h;
    wv = w;
    b = (wv / (64'd1 << (8 * off))) % 256;
    h = (wv / (64'd1 << (16 * (off / 2)))) % 65536;
    case (f3)
      0: return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
      4: return 32'(b);
      1: return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
      5: return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic idle_in();
    bus.i_ce = 0; bus.i_flush = 0; bus.i_mem_ack = 0;
    bus.i_opcode_load = 0; bus.i_opcode_system = 0;
    bus.i_wr_rd = 0; bus.i_rd_addr = 5'($urandom);
    bus.i_alu_result = $urandom; bus.i_csr_out = $urandom;
    bus.i_funct3 = 3'($urandom); bus.i_mem_rdata = $urandom;
  endtask

  task automatic check_port(input string tag,
                            input bit wr, input bit stall);
    chk({tag, ".wr"}, 32'(bus.o_wr), 32'(wr));
    chk({tag, ".addr"}, 32'(bus.o_rd_addr), 32'(exp_addr));
    chk({tag, ".rd"}, bus.o_rd, exp_rd);
    chk({tag, ".stall"}, 32'(bus.o_stall), 32'(stall));
  endtask

  // Issue one instruction; loads may wait `delay` cycles,
  // and a flush may coincide with the ack cycle.
  task automatic run_instr(
    input string tag, input bit ld, input bit sys,
    input logic [4:0] rd, input bit wr,
    input logic [31:0] alu, input logic [31:0] csr,
    input logic [2:0] f3, input logic [31:0] rdata,
    input int delay, input bit fl);
    logic [31:0] val;
    if (ld) val = ref_load(rdata, int'(f3), int'(alu % 4));
    else if (sys) val = csr;
    else val = alu;
    @(negedge clk);
    idle_in();
    bus.i_ce = 1; bus.i_opcode_load = ld;
    bus.i_opcode_system = sys; bus.i_rd_addr = rd;
    bus.i_wr_rd = wr; bus.i_alu_result = alu;
    bus.i_csr_out = csr; bus.i_funct3 = f3;
    if (ld && delay == 0) begin
      bus.i_mem_ack = 1; bus.i_mem_rdata = rdata;
    end
    #1 chk({tag, ".ce_acc"}, 32'(bus.o_ce_stage5), 1);
    @(posedge clk); #1;
    if (!ld || delay == 0) begin
      exp_rd = val; exp_addr = rd;
      check_port(tag, wr && rd != 0, 0);
    end else begin
      chk({tag, ".wr0"}, 32'(bus.o_wr), 0);
      chk({tag, ".stall0"}, 32'(bus.o_stall), 1);
      for (int d = 1; d <= delay; d++) begin
        @(negedge clk);
        idle_in();
        bus.i_ce = 1;
        bus.i_opcode_load = 1'($urandom);
        if (d == delay) begin
          bus.i_mem_ack = 1; bus.i_mem_rdata = rdata;
          bus.i_flush = fl;
        end
        #1 chk({tag, ".ce_st"}, 32'(bus.o_ce_stage5), 0);
        chk({tag, ".stall_w"}, 32'(bus.o_stall), 1);
        @(posedge clk); #1;
        if (d < delay) begin
          chk({tag, ".wr_w"}, 32'(bus.o_wr), 0);
        end else if (fl) begin
          check_port({tag, ".fl"}, 0, 0);
        end else begin
          exp_rd = val; exp_addr = rd;
          check_port({tag, ".ack"}, wr && rd != 0, 0);
        end
      end
    end
    @(negedge clk);
    idle_in();
    bus.i_mem_ack = 1'($urandom);
    @(posedge clk); #1;
    check_port({tag, ".idle"}, 0, 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [2:0]  f3s [5];
    checks = 0; passes = 0;
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    exp_rd = 0; exp_addr = 0;
    idle_in();
    rst_n = 0;
    #12;
    chk("rst.wr", 32'(bus.o_wr), 0);
    chk("rst.rd", bus.o_rd, 0);
    chk("rst.addr", 32'(bus.o_rd_addr), 0);
    chk("rst.stall", 32'(bus.o_stall), 0);
    @(negedge clk); rst_n = 1;

    run_instr("alu", 0, 0, 5'd5, 1, 32'h12345678,
              0, 0, 0, 0, 0);
    w = 32'h80F07F81;
    run_instr("lb0", 1, 0, 1, 1, 32'h100, 0, 3'b000, w, 0, 0);
    chk("lb0.val", exp_rd, 32'hFFFFFF81);
    run_instr("lbu3", 1, 0, 2, 1, 32'h103, 0, 3'b100, w, 0, 0);
    chk("lbu3.val", exp_rd, 32'h00000080);
    run_instr("lh2", 1, 0, 3, 1, 32'h102, 0, 3'b001, w, 0, 0);
    chk("lh2.val", exp_rd, 32'hFFFF80F0);
    run_instr("lhu0", 1, 0, 4, 1, 32'h100, 0, 3'b101, w, 0, 0);
    chk("lhu0.val", exp_rd, 32'h00007F81);
    run_instr("lw", 1, 0, 6, 1, 32'h100, 0, 3'b010, w, 0, 0);
    chk("lw.val", exp_rd, 32'h80F07F81);
    run_instr("ldly", 1, 0, 7, 1, 32'h201, 0, 3'b000,
              32'h0000_9C00, 3, 0);
    run_instr("lfl", 1, 0, 9, 1, 32'h200, 0, 3'b010,
              32'hCAFEF00D, 2, 1);
    run_instr("csr0", 0, 1, 0, 1, 32'h1, 32'hDEAD0001,
              0, 0, 0, 0);
    run_instr("csr3", 0, 1, 3, 1, 32'h1, 32'hDEAD0001,
              0, 0, 0, 0);

    // flush while in RUN blocks acceptance
    @(negedge clk);
    idle_in();
    bus.i_ce = 1; bus.i_flush = 1; bus.i_wr_rd = 1;
    bus.i_rd_addr = 5'd12;
    #1 chk("flrun.ce", 32'(bus.o_ce_stage5), 0);
    @(posedge clk); #1;
    check_port("flrun", 0, 0);

    for (int n = 0; n < 60; n++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      a = $urandom;
      run_instr($sformatf("rnd%0d", n), k == 2, k == 1,
                5'($urandom), 1'($urandom), a, $urandom,
                3'($urandom), $urandom,
                (k == 2) ? $urandom_range(0, 3) : 0,
                $urandom_range(0, 4) == 0);
    end
    for (int i = 0; i < 5; i++)
      run_instr($sformatf("lall%0d", i), 1, 0, 5'd8, 1,
                32'h300 + 32'(i % 4), 0, f3s[i], w, 1, 0);

    // async reset while waiting on a load
    run_instr("pre", 0, 0, 5'd10, 1, 32'hA5A5A5A5,
              0, 0, 0, 0, 0);
    @(negedge clk);
    idle_in();
    bus.i_ce = 1; bus.i_opcode_load = 1;
    bus.i_rd_addr = 5'd11; bus.i_wr_rd = 1;
    @(posedge clk); #1;
    chk("ar.stall_pre", 32'(bus.o_stall), 1);
    @(negedge clk);
    idle_in();
    #2 rst_n = 0;
    #1;
    chk("ar.stall", 32'(bus.o_stall), 0);
    chk("ar.wr", 32'(bus.o_wr), 0);
    chk("ar.rd", bus.o_rd, 0);
    @(negedge clk); rst_n = 1;
    exp_rd = 0; exp_addr = 0;
    @(negedge clk);
    bus.i_mem_ack = 1;
    @(posedge clk); #1;
    check_port("ar.post", 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_writeback.md
Name: rv32i_writeback

Overview:
- Stage 5 (WRITEBACK) of the 5-stage RV32I pipeline.
- Consumes the memory-stage result, aligns and sign-extends load data, and selects ALU/CSR/load data as the destination value.
- Drives the base register file write port with registered outputs; that port samples its stage-enable one cycle late, so the two line up.
- Holds the pipeline while a load response is outstanding.

Parameters:
- none

Ports:
- i_clk  input  1  pipeline clock
- i_rst_n  input  1  asynchronous active-low reset
- i_ce  input  1  stage-5 clock enable from the pipeline; instruction valid in this stage
- i_flush  input  1  discard the instruction in this stage and any pending load
- i_rd_addr  input  5  destination register address
- i_wr_rd  input  1  instruction writes rd
- i_alu_result  input  32  ALU result; for loads, the byte address (bits [1:0] = byte offset)
- i_csr_out  input  32  CSR read value
- i_opcode_load  input  1  instruction is LOAD
- i_opcode_system  input  1  instruction is SYSTEM/CSR (select i_csr_out)
- i_funct3  input  3  load width/sign
- i_mem_rdata  input  32  data memory read word
- i_mem_ack  input  1  data memory response valid this cycle
- o_ce_stage5  output  1  stage-enable to the register file
- o_rd_addr  output  5  registered rd address
- o_rd  output  32  registered rd data
- o_wr  output  1  registered write enable
- o_stall  output  1  writeback busy; upstream stages must hold

Behaviour:
- Reset (async, i_rst_n=0):
  - o_rd_addr=0, o_rd=0, o_wr=0, o_stall=0.
  - State=RUN; internal latches cleared.
- o_ce_stage5 = i_ce & ~o_stall & ~i_flush (combinational).
- Accept: instruction accepted on a rising edge where o_ce_stage5=1.
- Latency: outputs updated on the same edge as acceptance, so they are valid the cycle after.
- States:
  - RUN, non-load accepted:
    - o_rd = i_csr_out if i_opcode_system, else i_alu_result.
    - o_wr = i_wr_rd; o_rd_addr = i_rd_addr. Stay in RUN.
  - RUN, load accepted with i_mem_ack=1 the same cycle:
    - o_rd = aligned load data; o_wr = i_wr_rd. Stay in RUN.
  - RUN, load accepted with i_mem_ack=0:
    - Latch rd_addr, wr_rd, funct3 and offset; o_wr=0; go to WAIT_LOAD.
  - WAIT_LOAD:
    - o_stall=1 (combinational from state); o_wr=0 each cycle.
    - On i_mem_ack=1: o_rd = aligned data from latched funct3/offset; o_rd_addr = latched address; o_wr = latched wr_rd; go to RUN.
    - o_stall drops the cycle after the ack.
- Cycles with no acceptance (and not completing a load): o_wr=0 next edge; o_rd and o_rd_addr hold.
- Load alignment (off = addr[1:0]):
  - LB(000) / LBU(100): byte off, sign- or zero-extended.
  - LH(001) / LHU(101): halfword selected by off[1]; off[0] ignored (misalignment trapped upstream).
  - LW(010), and 011/110/111: full word.
- o_wr is forced 0 when rd address is 0; the register file also ignores x0.
- i_flush:
  - In RUN: next edge o_wr=0; nothing accepted.
  - In WAIT_LOAD: return to RUN, o_wr=0; an ack in that cycle is dropped.
  - Flush has priority over a simultaneous ack.
- Reset mid-WAIT_LOAD: immediate return to RUN, o_stall=0, no write.
- i_mem_ack while in RUN with no load accepted: ignored.

Test Plan:
- Reset, then accept ALU op (rd=5, alu=0x12345678, wr=1) -> next cycle o_wr=1, o_rd_addr=5, o_rd=0x12345678, o_ce_stage5 high during acceptance cycle.
- Loads with i_mem_rdata=0x80F0_7F81 and immediate ack:
  - LB off=0 -> 0xFFFFFF81
  - LBU off=3 -> 0x00000080
  - LH off=2 -> 0xFFFF80F0
  - LHU off=0 -> 0x00007F81
  - LW -> 0x80F07F81
- Load with ack delayed 3 cycles (rd=7) -> o_stall=1 for 3 cycles, o_ce_stage5=0 while stalled, then o_wr=1, o_rd_addr=7 for exactly one cycle, o_stall=0 after.
- Flush during WAIT_LOAD with simultaneous ack -> no write, state RUN, o_stall=0 next cycle.
- CSR op (i_opcode_system=1, csr_out=0xDEAD0001, rd=0, wr=1) -> o_wr=0; same op with rd=3 -> o_rd=0xDEAD0001, o_wr=1.
- Assert i_rst_n=0 asynchronously mid-WAIT_LOAD -> o_stall, o_wr, o_rd clear immediately without a clock edge.
